// File: rtl/core_pkg.sv
// Shared definitions for the RV32IM core: ALU opcodes, operand select codes
// and the bit positions inside the 5-bit control bundle.
package core_pkg;

    localparam int XLEN    = 32;
    localparam int RADDR_W = 5;

    localparam logic [3:0] ALU_ADD  = 4'b0000;
    localparam logic [3:0] ALU_SUB  = 4'b1000;
    localparam logic [3:0] ALU_SLL  = 4'b0001;
    localparam logic [3:0] ALU_SLT  = 4'b0010;
    localparam logic [3:0] ALU_SLTU = 4'b0011;
    localparam logic [3:0] ALU_XOR  = 4'b0100;
    localparam logic [3:0] ALU_SRL  = 4'b0101;
    localparam logic [3:0] ALU_SRA  = 4'b1101;
    localparam logic [3:0] ALU_OR   = 4'b0110;
    localparam logic [3:0] ALU_AND  = 4'b0111;
    localparam logic [3:0] ALU_BEQ  = 4'b1111;
    localparam logic [3:0] ALU_BNE  = 4'b1110;
    localparam logic [3:0] ALU_BGE  = 4'b1100;
    localparam logic [3:0] ALU_BGEU = 4'b1001;

    localparam logic [1:0] OP1_RS1   = 2'b00;
    localparam logic [1:0] OP1_PC    = 2'b01;
    localparam logic [1:0] OP1_ZERO  = 2'b10;
    localparam logic [1:0] OP1_ZERO2 = 2'b11;

    localparam logic [1:0] OP2_RS2  = 2'b00;
    localparam logic [1:0] OP2_IMM  = 2'b01;
    localparam logic [1:0] OP2_FOUR = 2'b10;
    localparam logic [1:0] OP2_ZERO = 2'b11;

    localparam int CTRL_REG_WRITE = 0;
    localparam int CTRL_MEM_READ  = 1;
    localparam int CTRL_MEM_WRITE = 2;
    localparam int CTRL_BRANCH    = 3;
    localparam int CTRL_JUMP      = 4;

    typedef enum logic [1:0] {
        UPD_FLUSH,
        UPD_HOLD,
        UPD_BUBBLE,
        UPD_CAPTURE
    } upd_e;

endpackage

// File: rtl/fwd_mux.sv
// Per-source forwarding selector: EX/MEM beats MEM/WB beats the registered
// operand; x0 always reads zero.
module fwd_mux
    import core_pkg::*;
#(
    parameter int XLEN    = core_pkg::XLEN,
    parameter int RADDR_W = core_pkg::RADDR_W
) (
    input  logic [RADDR_W-1:0] rs_addr_i,
    input  logic [XLEN-1:0]    rs_data_i,
    input  logic [RADDR_W-1:0] exmem_rd_i,
    input  logic               exmem_we_i,
    input  logic [XLEN-1:0]    exmem_result_i,
    input  logic [RADDR_W-1:0] memwb_rd_i,
    input  logic               memwb_we_i,
    input  logic [XLEN-1:0]    memwb_result_i,
    output logic [XLEN-1:0]    data_o
);

    always_comb begin
        data_o = rs_data_i;
        if (rs_addr_i == '0) begin
            data_o = '0;
        end else if (exmem_we_i && exmem_rd_i == rs_addr_i) begin
            data_o = exmem_result_i;
        end else if (memwb_we_i && memwb_rd_i == rs_addr_i) begin
            data_o = memwb_result_i;
        end
    end

endmodule

// File: rtl/id_ex_stage.sv
// ID/EX pipeline register with load-use detection, capture bypass from
// MEM/WB and EX-side forwarding/operand selection feeding the ALU.
module id_ex_stage
    import core_pkg::*;
#(
    parameter int XLEN    = core_pkg::XLEN,
    parameter int RADDR_W = core_pkg::RADDR_W
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic               stall_i,
    input  logic               flush_i,
    input  logic               id_valid,
    input  logic [XLEN-1:0]    id_pc,
    input  logic [XLEN-1:0]    id_imm,
    input  logic [RADDR_W-1:0] id_rs1_addr,
    input  logic [RADDR_W-1:0] id_rs2_addr,
    input  logic [XLEN-1:0]    id_rs1_data,
    input  logic [XLEN-1:0]    id_rs2_data,
    input  logic               id_rs1_used,
    input  logic               id_rs2_used,
    input  logic [RADDR_W-1:0] id_rd,
    input  logic [3:0]         id_alu_op,
    input  logic [1:0]         id_op1_sel,
    input  logic [1:0]         id_op2_sel,
    input  logic [4:0]         id_ctrl,
    input  logic [RADDR_W-1:0] exmem_rd,
    input  logic [RADDR_W-1:0] memwb_rd,
    input  logic               exmem_we,
    input  logic               memwb_we,
    input  logic [XLEN-1:0]    exmem_result,
    input  logic [XLEN-1:0]    memwb_result,
    output logic               load_use_stall,
    output logic               ex_valid,
    output logic [XLEN-1:0]    ex_pc,
    output logic [XLEN-1:0]    ex_imm,
    output logic [RADDR_W-1:0] ex_rd,
    output logic [4:0]         ex_ctrl,
    output logic [3:0]         ex_alu_op,
    output logic [XLEN-1:0]    ex_operand1,
    output logic [XLEN-1:0]    ex_operand2,
    output logic [XLEN-1:0]    ex_store_data
);

    logic               valid_q,    valid_d;
    logic [XLEN-1:0]    pc_q,       pc_d;
    logic [XLEN-1:0]    imm_q,      imm_d;
    logic [RADDR_W-1:0] rs1_addr_q, rs1_addr_d;
    logic [RADDR_W-1:0] rs2_addr_q, rs2_addr_d;
    logic [XLEN-1:0]    rs1_data_q, rs1_data_d;
    logic [XLEN-1:0]    rs2_data_q, rs2_data_d;
    logic [RADDR_W-1:0] rd_q,       rd_d;
    logic [3:0]         alu_op_q,   alu_op_d;
    logic [1:0]         op1_sel_q,  op1_sel_d;
    logic [1:0]         op2_sel_q,  op2_sel_d;
    logic [4:0]         ctrl_q,     ctrl_d;

    upd_e            upd;
    logic [XLEN-1:0] rs1_cap, rs2_cap;
    logic [XLEN-1:0] rs1_fwd, rs2_fwd;

    assign load_use_stall = valid_q && ctrl_q[CTRL_MEM_READ] && (rd_q != '0) && id_valid
                          && ((id_rs1_used && id_rs1_addr == rd_q)
                           || (id_rs2_used && id_rs2_addr == rd_q));

    // The register file is written this same cycle, so MEM/WB data must be latched here.
    assign rs1_cap = (memwb_we && memwb_rd != '0 && memwb_rd == id_rs1_addr) ? memwb_result : id_rs1_data;
    assign rs2_cap = (memwb_we && memwb_rd != '0 && memwb_rd == id_rs2_addr) ? memwb_result : id_rs2_data;

    always_comb begin
        if (flush_i)             upd = UPD_FLUSH;
        else if (stall_i)        upd = UPD_HOLD;
        else if (load_use_stall) upd = UPD_BUBBLE;
        else                     upd = UPD_CAPTURE;
    end

    always_comb begin
        valid_d    = valid_q;
        pc_d       = pc_q;
        imm_d      = imm_q;
        rs1_addr_d = rs1_addr_q;
        rs2_addr_d = rs2_addr_q;
        rs1_data_d = rs1_data_q;
        rs2_data_d = rs2_data_q;
        rd_d       = rd_q;
        alu_op_d   = alu_op_q;
        op1_sel_d  = op1_sel_q;
        op2_sel_d  = op2_sel_q;
        ctrl_d     = ctrl_q;
        case (upd)
            UPD_FLUSH, UPD_BUBBLE: begin
                valid_d    = 1'b0;
                pc_d       = '0;
                imm_d      = '0;
                rs1_addr_d = '0;
                rs2_addr_d = '0;
                rs1_data_d = '0;
                rs2_data_d = '0;
                rd_d       = '0;
                alu_op_d   = ALU_ADD;
                op1_sel_d  = OP1_RS1;
                op2_sel_d  = OP2_RS2;
                ctrl_d     = '0;
            end
            UPD_CAPTURE: begin
                valid_d    = id_valid;
                pc_d       = id_pc;
                imm_d      = id_imm;
                rs1_addr_d = id_rs1_addr;
                rs2_addr_d = id_rs2_addr;
                rs1_data_d = rs1_cap;
                rs2_data_d = rs2_cap;
                rd_d       = id_rd;
                alu_op_d   = id_alu_op;
                op1_sel_d  = id_op1_sel;
                op2_sel_d  = id_op2_sel;
                ctrl_d     = id_valid ? id_ctrl : 5'b0;
            end
            default: ;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            valid_q    <= 1'b0;
            pc_q       <= '0;
            imm_q      <= '0;
            rs1_addr_q <= '0;
            rs2_addr_q <= '0;
            rs1_data_q <= '0;
            rs2_data_q <= '0;
            rd_q       <= '0;
            alu_op_q   <= ALU_ADD;
            op1_sel_q  <= OP1_RS1;
            op2_sel_q  <= OP2_RS2;
            ctrl_q     <= '0;
        end else begin
            valid_q    <= valid_d;
            pc_q       <= pc_d;
            imm_q      <= imm_d;
            rs1_addr_q <= rs1_addr_d;
            rs2_addr_q <= rs2_addr_d;
            rs1_data_q <= rs1_data_d;
            rs2_data_q <= rs2_data_d;
            rd_q       <= rd_d;
            alu_op_q   <= alu_op_d;
            op1_sel_q  <= op1_sel_d;
            op2_sel_q  <= op2_sel_d;
            ctrl_q     <= ctrl_d;
        end
    end

    fwd_mux #(.XLEN(XLEN), .RADDR_W(RADDR_W)) u_fwd_rs1 (
        .rs_addr_i      (rs1_addr_q),
        .rs_data_i      (rs1_data_q),
        .exmem_rd_i     (exmem_rd),
        .exmem_we_i     (exmem_we),
        .exmem_result_i (exmem_result),
        .memwb_rd_i     (memwb_rd),
        .memwb_we_i     (memwb_we),
        .memwb_result_i (memwb_result),
        .data_o         (rs1_fwd)
    );

    fwd_mux #(.XLEN(XLEN), .RADDR_W(RADDR_W)) u_fwd_rs2 (
        .rs_addr_i      (rs2_addr_q),
        .rs_data_i      (rs2_data_q),
        .exmem_rd_i     (exmem_rd),
        .exmem_we_i     (exmem_we),
        .exmem_result_i (exmem_result),
        .memwb_rd_i     (memwb_rd),
        .memwb_we_i     (memwb_we),
        .memwb_result_i (memwb_result),
        .data_o         (rs2_fwd)
    );

    always_comb begin
        case (op1_sel_q)
            OP1_RS1: ex_operand1 = rs1_fwd;
            OP1_PC:  ex_operand1 = pc_q;
            default: ex_operand1 = '0;
        endcase
        case (op2_sel_q)
            OP2_RS2:  ex_operand2 = rs2_fwd;
            OP2_IMM:  ex_operand2 = imm_q;
            OP2_FOUR: ex_operand2 = XLEN'(4);
            default:  ex_operand2 = '0;
        endcase
    end

    assign ex_valid      = valid_q;
    assign ex_pc         = pc_q;
    assign ex_imm        = imm_q;
    assign ex_rd         = rd_q;
    assign ex_ctrl       = ctrl_q;
    assign ex_alu_op     = alu_op_q;
    assign ex_store_data = rs2_fwd;

endmodule

// File: tb/tb_id_ex_stage.sv
// Directed bench for id_ex_stage: reset, capture, forwarding priority, x0,
// load-use bubble with capture bypass, flush/stall interplay and stall hold.
module tb_id_ex_stage;

    logic        clk;
    logic        rst_n;
    logic        stall_i;
    logic        flush_i;
    logic        id_valid;
    logic [31:0] id_pc, id_imm;
    logic [4:0]  id_rs1_addr, id_rs2_addr;
    logic [31:0] id_rs1_data, id_rs2_data;
    logic        id_rs1_used, id_rs2_used;
    logic [4:0]  id_rd;
    logic [3:0]  id_alu_op;
    logic [1:0]  id_op1_sel, id_op2_sel;
    logic [4:0]  id_ctrl;
    logic [4:0]  exmem_rd, memwb_rd;
    logic        exmem_we, memwb_we;
    logic [31:0] exmem_result, memwb_result;
    logic        load_use_stall;
    logic        ex_valid;
    logic [31:0] ex_pc, ex_imm;
    logic [4:0]  ex_rd;
    logic [4:0]  ex_ctrl;
    logic [3:0]  ex_alu_op;
    logic [31:0] ex_operand1, ex_operand2, ex_store_data;

    int nAsserts = 0;
    int nFails   = 0;

    id_ex_stage dut (
        .clk            (clk),
        .rst_n          (rst_n),
        .stall_i        (stall_i),
        .flush_i        (flush_i),
        .id_valid       (id_valid),
        .id_pc          (id_pc),
        .id_imm         (id_imm),
        .id_rs1_addr    (id_rs1_addr),
        .id_rs2_addr    (id_rs2_addr),
        .id_rs1_data    (id_rs1_data),
        .id_rs2_data    (id_rs2_data),
        .id_rs1_used    (id_rs1_used),
        .id_rs2_used    (id_rs2_used),
        .id_rd          (id_rd),
        .id_alu_op      (id_alu_op),
        .id_op1_sel     (id_op1_sel),
        .id_op2_sel     (id_op2_sel),
        .id_ctrl        (id_ctrl),
        .exmem_rd       (exmem_rd),
        .memwb_rd       (memwb_rd),
        .exmem_we       (exmem_we),
        .memwb_we       (memwb_we),
        .exmem_result   (exmem_result),
        .memwb_result   (memwb_result),
        .load_use_stall (load_use_stall),
        .ex_valid       (ex_valid),
        .ex_pc          (ex_pc),
        .ex_imm         (ex_imm),
        .ex_rd          (ex_rd),
        .ex_ctrl        (ex_ctrl),
        .ex_alu_op      (ex_alu_op),
        .ex_operand1    (ex_operand1),
        .ex_operand2    (ex_operand2),
        .ex_store_data  (ex_store_data)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
        nAsserts++;
        assert (observed === expected)
        else begin
            nFails++;
            $error("[TB] FAIL %s: observed=0x%08h expected=0x%08h", tag, observed, expected);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic applyStimulus(
        input logic        valid,
        input logic [31:0] pc,
        input logic [31:0] imm,
        input logic [4:0]  rs1,
        input logic [31:0] rs1Data,
        input logic        rs1Used,
        input logic [4:0]  rs2,
        input logic [31:0] rs2Data,
        input logic        rs2Used,
        input logic [4:0]  rd,
        input logic [3:0]  aluOp,
        input logic [1:0]  op1Sel,
        input logic [1:0]  op2Sel,
        input logic [4:0]  ctrl
    );
        id_valid    = valid;
        id_pc       = pc;
        id_imm      = imm;
        id_rs1_addr = rs1;
        id_rs1_data = rs1Data;
        id_rs1_used = rs1Used;
        id_rs2_addr = rs2;
        id_rs2_data = rs2Data;
        id_rs2_used = rs2Used;
        id_rd       = rd;
        id_alu_op   = aluOp;
        id_op1_sel  = op1Sel;
        id_op2_sel  = op2Sel;
        id_ctrl     = ctrl;
    endtask

    initial begin
        rst_n        = 1'b0;
        stall_i      = 1'b0;
        flush_i      = 1'b0;
        exmem_rd     = 5'd0;
        memwb_rd     = 5'd0;
        exmem_we     = 1'b0;
        memwb_we     = 1'b0;
        exmem_result = 32'h0;
        memwb_result = 32'h0;
        applyStimulus(1'b0, 32'h0, 32'h0, 5'd0, 32'h0, 1'b0, 5'd0, 32'h0, 1'b0, 5'd0, 4'h0, 2'b00, 2'b00, 5'h00);
        #2;
        checkOutput("reset_valid", 32'(ex_valid), 32'h0);
        checkOutput("reset_ctrl", 32'(ex_ctrl), 32'h0);
        checkOutput("reset_aluop", 32'(ex_alu_op), 32'h0);
        checkOutput("reset_op1", ex_operand1, 32'h0);
        checkOutput("reset_op2", ex_operand2, 32'h0);
        checkOutput("reset_store", ex_store_data, 32'h0);
        checkOutput("reset_lus", 32'(load_use_stall), 32'h0);
        @(negedge clk);
        rst_n = 1'b1;

        // add x3, x1, x2
        applyStimulus(1'b1, 32'h100, 32'h10, 5'd1, 32'hA, 1'b1, 5'd2, 32'hB, 1'b1, 5'd3, 4'b0000, 2'b00, 2'b00, 5'h01);
        tick();
        checkOutput("cap_valid", 32'(ex_valid), 32'h1);
        checkOutput("cap_pc", ex_pc, 32'h100);
        checkOutput("cap_op1", ex_operand1, 32'hA);
        checkOutput("cap_op2", ex_operand2, 32'hB);
        checkOutput("cap_store", ex_store_data, 32'hB);
        checkOutput("cap_rd", 32'(ex_rd), 32'd3);
        checkOutput("cap_ctrl", 32'(ex_ctrl), 32'h01);

        // pc/imm select with SUB
        applyStimulus(1'b1, 32'h200, 32'hFFFF_FFF0, 5'd1, 32'hA, 1'b1, 5'd2, 32'hB, 1'b0, 5'd6, 4'b1000, 2'b01, 2'b01, 5'h01);
        tick();
        checkOutput("sel_op1_pc", ex_operand1, 32'h200);
        checkOutput("sel_op2_imm", ex_operand2, 32'hFFFF_FFF0);
        checkOutput("sel_aluop", 32'(ex_alu_op), 32'h8);
        checkOutput("sel_store_rs2", ex_store_data, 32'hB);

        // EX/MEM over MEM/WB priority, re-evaluated without a clock
        applyStimulus(1'b1, 32'h204, 32'h0, 5'd5, 32'h55, 1'b1, 5'd0, 32'h0, 1'b1, 5'd7, 4'b0000, 2'b00, 2'b11, 5'h01);
        tick();
        exmem_rd = 5'd5; exmem_we = 1'b1; exmem_result = 32'h11;
        memwb_rd = 5'd5; memwb_we = 1'b1; memwb_result = 32'h22;
        #1;
        checkOutput("fwd_exmem_prio", ex_operand1, 32'h11);
        checkOutput("fwd_op2_zero", ex_operand2, 32'h0);
        exmem_we = 1'b0;
        #1;
        checkOutput("fwd_memwb", ex_operand1, 32'h22);
        memwb_we = 1'b0;
        #1;
        checkOutput("fwd_none", ex_operand1, 32'h55);

        // x0 never forwarded, reads 0 even if register file returns junk
        applyStimulus(1'b1, 32'h208, 32'h0, 5'd0, 32'h1234, 1'b1, 5'd0, 32'h0, 1'b0, 5'd8, 4'b0000, 2'b00, 2'b00, 5'h01);
        tick();
        exmem_rd = 5'd0; exmem_we = 1'b1; exmem_result = 32'hFFFF;
        #1;
        checkOutput("x0_op1", ex_operand1, 32'h0);
        exmem_we = 1'b0;

        // lw x3, 4(x1) followed by add x4, x3, x1
        applyStimulus(1'b1, 32'h300, 32'h4, 5'd1, 32'h1000, 1'b1, 5'd0, 32'h0, 1'b0, 5'd3, 4'b0000, 2'b00, 2'b01, 5'h03);
        tick();
        checkOutput("lw_op2_imm", ex_operand2, 32'h4);
        applyStimulus(1'b1, 32'h304, 32'h0, 5'd3, 32'h0, 1'b1, 5'd1, 32'h7, 1'b1, 5'd4, 4'b0000, 2'b00, 2'b00, 5'h01);
        #1;
        checkOutput("lu_stall", 32'(load_use_stall), 32'h1);
        tick();
        checkOutput("lu_bubble_valid", 32'(ex_valid), 32'h0);
        checkOutput("lu_bubble_ctrl", 32'(ex_ctrl), 32'h0);
        checkOutput("lu_stall_clear", 32'(load_use_stall), 32'h0);
        memwb_rd = 5'd3; memwb_we = 1'b1; memwb_result = 32'hCAFE;
        tick();
        memwb_we = 1'b0;
        #1;
        checkOutput("lu_add_valid", 32'(ex_valid), 32'h1);
        checkOutput("lu_bypass_op1", ex_operand1, 32'hCAFE);
        checkOutput("lu_add_op2", ex_operand2, 32'h7);
        checkOutput("lu_add_rd", 32'(ex_rd), 32'd4);

        // flush wins over stall
        applyStimulus(1'b1, 32'h400, 32'h0, 5'd1, 32'h1, 1'b1, 5'd2, 32'h2, 1'b1, 5'd9, 4'b0100, 2'b00, 2'b00, 5'h05);
        flush_i = 1'b1; stall_i = 1'b1;
        tick();
        flush_i = 1'b0; stall_i = 1'b0;
        checkOutput("flush_valid", 32'(ex_valid), 32'h0);
        checkOutput("flush_ctrl", 32'(ex_ctrl), 32'h0);
        checkOutput("flush_rd", 32'(ex_rd), 32'h0);

        // stall hold with op2 = 4
        applyStimulus(1'b1, 32'h500, 32'h0, 5'd1, 32'h1, 1'b0, 5'd0, 32'h0, 1'b0, 5'd1, 4'b0000, 2'b01, 2'b10, 5'h11);
        tick();
        checkOutput("hold_op2_four", ex_operand2, 32'h4);
        stall_i = 1'b1;
        for (int i = 1; i <= 3; i++) begin
            id_pc = 32'h500 + 32'(4 * i);
            tick();
            checkOutput("hold_pc", ex_pc, 32'h500);
            checkOutput("hold_valid", 32'(ex_valid), 32'h1);
        end
        stall_i = 1'b0;
        tick();
        checkOutput("hold_release_pc", ex_pc, 32'h50C);

        // id_valid=0 forces ctrl to 0
        applyStimulus(1'b0, 32'h600, 32'h0, 5'd1, 32'h1, 1'b1, 5'd2, 32'h2, 1'b1, 5'd5, 4'b0000, 2'b00, 2'b00, 5'h1F);
        tick();
        checkOutput("novalid_valid", 32'(ex_valid), 32'h0);
        checkOutput("novalid_ctrl", 32'(ex_ctrl), 32'h0);

        // asynchronous reset mid-cycle
        applyStimulus(1'b1, 32'h700, 32'h9, 5'd5, 32'h77, 1'b1, 5'd5, 32'h77, 1'b1, 5'd10, 4'b0110, 2'b00, 2'b00, 5'h01);
        tick();
        exmem_rd = 5'd5; exmem_we = 1'b1; exmem_result = 32'hABCD;
        #1;
        checkOutput("pre_rst_op1", ex_operand1, 32'hABCD);
        #1;
        rst_n = 1'b0;
        #1;
        checkOutput("async_rst_valid", 32'(ex_valid), 32'h0);
        checkOutput("async_rst_ctrl", 32'(ex_ctrl), 32'h0);
        checkOutput("async_rst_op1", ex_operand1, 32'h0);
        checkOutput("async_rst_op2", ex_operand2, 32'h0);
        checkOutput("async_rst_store", ex_store_data, 32'h0);

        $display("End of test - %0d assertions evaluated, %0d failures", nAsserts, nFails);
        $finish;
    end

endmodule
